fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage for the onboard single-cycle core. Holds the PC and
//  fetches from IROM over a req/ack handshake. Presents one instruction at a time
//  to the decode/control logic and computes the next PC from npc_op when execute
//  signals completion. Sits between IROM and control.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset
//  NOP_INST   32'h0000_0013   value driven on inst when none held (addi x0,x0,0)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  npc_op       in   2   next-PC select, `NPC_PC4/`NPC_BEQ/`NPC_JMP/`NPC_ALU
//  ext          in   32  sign-extended immediate from sext
//  alu_c        in   32  ALU result (JALR target)
//  ex_done      in   1   execute/writeback finished current inst (1-cycle pulse)
//  imem_req     out  1   fetch request to IROM
//  imem_addr    out  32  fetch address (= pc)
//  imem_ack     in   1   IROM data valid for current request
//  imem_rdata   in   32  IROM instruction word
//  inst         out  32  held instruction to control/decode
//  inst_valid   out  1   inst holds a fetched, not-yet-retired instruction
//  pc           out  32  PC of inst
//  pc4          out  32  pc + 4 (for WB_PC4)
//  misalign     out  1   sticky: computed next PC had addr[1:0] != 0
//  inst_count   out  32  retired-instruction counter
// BEHAVIOUR
//  Reset (rst=1 at an edge, dominates all other inputs): state=IDLE, pc=RESET_PC,
//   inst=NOP_INST, inst_valid=0, imem_req=0, misalign=0, inst_count=0.
//  FSM states: IDLE, FETCH, EXEC, HALT.
//   IDLE : imem_req=0; next cycle -> FETCH (unconditional).
//   FETCH: imem_req=1, imem_addr=pc, held stable until ack. On imem_ack:
//          inst<=imem_rdata, inst_valid<=1 -> EXEC. Zero-wait ack (same cycle as
//          first req cycle) is legal. No limit on wait cycles.
//   EXEC : imem_req=0. On ex_done: pc<=npc, inst<=NOP_INST, inst_valid<=0,
//          inst_count<=inst_count+1 (wraps 2^32-1 -> 0). Then -> FETCH if
//          npc[1:0]==0, else -> HALT with misalign<=1 and pc unchanged.
//   HALT : imem_req=0, inst_valid=0; leaves only on rst.
//  npc (combinational, 32-bit, carries discarded):
//   `NPC_PC4 -> pc+4;  `NPC_BEQ, `NPC_JMP -> pc+ext;  `NPC_ALU -> alu_c & ~32'h1.
//   Unknown code -> pc+4.
//  pc4 = pc+4 at all times (wraps at 32'hFFFF_FFFC -> 0).
//  Inputs ignored outside their state: imem_ack outside FETCH, ex_done outside EXEC.
//  Latency: ack -> inst_valid high next cycle; ex_done -> next imem_req next cycle.
//  Minimum 2 cycles per instruction (FETCH w/ zero-wait ack, EXEC w/ ex_done).
//  Reset mid-FETCH drops imem_req at the next edge. IROM shares rst, so no stale
//   ack is outstanding.
//  Reset mid-EXEC discards the held instruction; inst_count is not incremented.
// TESTING
//  1 Reset: rst 2 cycles -> pc=0, inst=32'h13, inst_valid=0, imem_req=0; cycle
//    after IDLE imem_req=1, imem_addr=0.
//  2 Wait states: ack after 3 cycles, rdata=32'h00500093 -> req/addr held stable
//    3 cycles, inst=32'h00500093, inst_valid=1 next cycle, req=0.
//  3 Sequential: 4 insts, zero-wait ack, npc_op=PC4 -> addrs 0,4,8,C;
//    inst_count=4; 2 cycles/inst.
//  4 Branch/jump: pc=8, npc_op=BEQ, ext=32'hFFFF_FFF8 -> next addr 0; pc=0,
//    npc_op=ALU, alu_c=32'h101 -> next addr 32'h100.
//  5 Misalign: npc_op=JMP, ext=32'h2 at pc=0 -> misalign=1, HALT, pc stays 0,
//    req stays 0 under further ack/ex_done; rst clears.
//  6 Reset mid-op: rst during FETCH wait and during EXEC -> req drops next edge;
//    pc=RESET_PC; inst_count unchanged by discarded inst, then reset to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the single-cycle core.
//   Holds the PC, fetches one word from IROM over a req/ack handshake, presents
//   it to decode until execute reports completion, then steps the PC.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   npc_op, ext, alu_c next-PC select and its operands
//   ex_done            execute finished the held instruction (1-cycle pulse)
//   imem_req/addr/ack/rdata  IROM handshake
//   inst, inst_valid, pc, pc4  held instruction and its PC
//   misalign           sticky flag: a computed next PC was not word aligned
//   inst_count         retired-instruction counter

`ifndef NPC_PC4
`define NPC_PC4 2'b00
`endif
`ifndef NPC_BEQ
`define NPC_BEQ 2'b01
`endif
`ifndef NPC_JMP
`define NPC_JMP 2'b10
`endif
`ifndef NPC_ALU
`define NPC_ALU 2'b11
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_op,
  input  logic [31:0] ext,
  input  logic [31:0] alu_c,
  input  logic        ex_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        misalign,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] npc;
  logic        npc_ok;

  // Next PC; JALR target has bit 0 cleared. Carries out of bit 31 are dropped.
  always_comb begin
    npc = pc + 32'd4;
    case (npc_op)
      `NPC_PC4: npc = pc + 32'd4;
      `NPC_BEQ: npc = pc + ext;
      `NPC_JMP: npc = pc + ext;
      `NPC_ALU: npc = alu_c & ~32'h1;
      default:  npc = pc + 32'd4;
    endcase
  end

  assign npc_ok = (npc[1:0] == 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = EXEC;
      EXEC:    if (ex_done)  state_nxt = npc_ok ? FETCH : HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      misalign   <= 1'b0;
      inst_count <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: if (imem_ack) inst <= imem_rdata;
        EXEC: if (ex_done) begin
          inst       <= NOP_INST;
          inst_count <= inst_count + 32'd1;
          // A misaligned target is never fetched; pc keeps the faulting inst's PC.
          if (npc_ok) pc <= npc;
          else        misalign <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == EXEC);
  assign pc4        = pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [1:0] OP_PC4 = 2'b00;
  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  npc_op = OP_PC4;
  logic [31:0] ext = 32'd0;
  logic [31:0] alu_c = 32'd0;
  logic        ex_done = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;
  logic [31:0] inst_count;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .npc_op(npc_op), .ext(ext), .alu_c(alu_c),
    .ex_done(ex_done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
    .inst_valid(inst_valid), .pc(pc), .pc4(pc4), .misalign(misalign),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, then one edge out of IDLE: leaves the DUT in FETCH.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; ex_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // One instruction with zero-wait ack: exactly one FETCH and one EXEC cycle.
  task automatic do_inst(input logic [31:0] exp_addr, input logic [31:0] word,
                         input logic [1:0] op, input logic [31:0] e,
                         input logic [31:0] a);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    chk("exec_inst", inst, word);
    chk("exec_valid", {31'd0, inst_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_pc", pc, exp_addr);
    chk("exec_pc4", pc4, exp_addr + 32'd4);
    npc_op = op; ext = e; alu_c = a; ex_done = 1'b1;
    tick();
    ex_done = 1'b0; npc_op = OP_PC4;
  endtask

  initial begin
    // 1: reset
    tick(); tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_cnt", inst_count, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_req", {31'd0, imem_req}, 32'd1);
    chk("idle_addr", imem_addr, 32'd0);

    // 2: three wait cycles, then ack
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'd0);
      chk("wait_valid", {31'd0, inst_valid}, 32'd0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0;
    chk("ws_inst", inst, 32'h0050_0093);
    chk("ws_valid", {31'd0, inst_valid}, 32'd1);
    chk("ws_req", {31'd0, imem_req}, 32'd0);

    // 3: four sequential instructions
    do_reset();
    do_inst(32'h0, 32'h1111_0013, OP_PC4, 32'd0, 32'd0);
    do_inst(32'h4, 32'h2222_0013, OP_PC4, 32'd0, 32'd0);
    do_inst(32'h8, 32'h3333_0013, OP_PC4, 32'd0, 32'd0);
    do_inst(32'hC, 32'h4444_0013, OP_PC4, 32'd0, 32'd0);
    chk("seq_cnt", inst_count, 32'd4);
    chk("seq_pc", pc, 32'h10);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("seq_inst_nop", inst, NOP);

    // 4: branch back, JALR, jump to top of memory, pc wrap
    do_reset();
    do_inst(32'h0, 32'hA, OP_PC4, 32'd0, 32'd0);
    do_inst(32'h4, 32'hB, OP_PC4, 32'd0, 32'd0);
    do_inst(32'h8, 32'hC, OP_BEQ, 32'hFFFF_FFF8, 32'd0);
    do_inst(32'h0, 32'hD, OP_ALU, 32'd0, 32'h101);
    do_inst(32'h100, 32'hE, OP_JMP, 32'hFFFF_FEFC, 32'd0);
    chk("top_pc4", pc4, 32'h0);
    do_inst(32'hFFFF_FFFC, 32'hF, OP_PC4, 32'd0, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("br_cnt", inst_count, 32'd6);
    chk("br_mis", {31'd0, misalign}, 32'd0);

    // 5: misaligned jump halts
    do_reset();
    do_inst(32'h0, 32'h1, OP_JMP, 32'h2, 32'd0);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_pc", pc, 32'd0);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    chk("mis_cnt", inst_count, 32'd1);
    imem_ack = 1'b1; ex_done = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, inst_valid}, 32'd0);
      chk("halt_pc", pc, 32'd0);
      chk("halt_mis", {31'd0, misalign}, 32'd1);
    end
    imem_ack = 1'b0; ex_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_mis", {31'd0, misalign}, 32'd0);
    chk("halt_rst_cnt", inst_count, 32'd0);

    // 6: reset during FETCH wait and during EXEC
    do_reset();
    tick();
    chk("mf_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mf_req_drop", {31'd0, imem_req}, 32'd0);
    chk("mf_pc", pc, 32'd0);
    rst = 1'b0;
    tick();
    do_inst(32'h0, 32'h5, OP_PC4, 32'd0, 32'd0);
    chk("me_cnt1", inst_count, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h6;
    tick();
    imem_ack = 1'b0;
    chk("me_valid", {31'd0, inst_valid}, 32'd1);
    rst = 1'b1; ex_done = 1'b1; npc_op = OP_PC4;
    tick();
    rst = 1'b0; ex_done = 1'b0;
    chk("me_cnt", inst_count, 32'd0);
    chk("me_pc", pc, 32'd0);
    chk("me_valid_drop", {31'd0, inst_valid}, 32'd0);
    chk("me_req", {31'd0, imem_req}, 32'd0);
    chk("me_inst", inst, NOP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
